// File: rtl/udc_counter.sv
`default_nettype none
//============================================================================
// Module   : udc_counter
// Purpose  : Parametrised up/down modulo counter with a built-in clock
//            prescaler. A 27-bit prescaler turns the board clock into a
//            one-cycle step event every CLK_DIVISION enabled cycles. Each step
//            moves the count one place up or down within 0..MODULUS-1.
//            Synchronous clear and load have priority over stepping. The
//            tick and terminal-count pulses allow digits to be cascaded.
//            Everything runs on udc_clk; no clock is ever derived.
// Ports    : udc_clk       in   1      system clock, rising edge
//            udc_rst_n     in   1      asynchronous reset, active-low
//            udc_en        in   1      count enable (gates prescaler + step)
//            udc_clr       in   1      synchronous clear (highest priority)
//            udc_dir       in   1      1 = up, 0 = down (sampled at step)
//            udc_load      in   1      synchronous load strobe
//            udc_load_val  in   WIDTH  load value (clamped to MODULUS-1)
//            udc_out       out  WIDTH  current count (registered)
//            udc_tick      out  1      pulse: count stepped this cycle
//            udc_tc        out  1      pulse: count wrapped / hit a boundary
// Config   : UDC_SATURATE_EN - when defined the count holds at its boundaries
//            instead of wrapping. udc_tc still pulses on each such step.
// Revision : 1.0 - initial release
//============================================================================
module udc_counter #(
    parameter int          WIDTH        = 4,
    parameter int          MODULUS      = 10,
    parameter logic [26:0] CLK_DIVISION = 27'd100000000
) (
    input  logic             udc_clk,
    input  logic             udc_rst_n,
    input  logic             udc_en,
    input  logic             udc_clr,
    input  logic             udc_dir,
    input  logic             udc_load,
    input  logic [WIDTH-1:0] udc_load_val,
    output logic [WIDTH-1:0] udc_out,
    output logic             udc_tick,
    output logic             udc_tc
);

    // The range comparisons use WIDTH+1 bits. MODULUS may equal 2**WIDTH,
    // and that value does not fit in WIDTH bits.
    localparam logic [WIDTH:0]   c_MOD      = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX      = WIDTH'(MODULUS - 1);
    localparam logic [26:0]      c_DIV_LAST = CLK_DIVISION - 27'd1;

    logic [26:0]      div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] out_q,     out_d;
    logic             tick_q,    tick_d;
    logic             tc_q,      tc_d;

    logic             step_evt;
    logic             load_over;
    logic             out_range;
    logic             at_max;
    logic             at_zero;

    assign step_evt  = udc_en && (div_cnt_q == c_DIV_LAST);
    assign load_over = {1'b0, udc_load_val} >= c_MOD;
    assign out_range = {1'b0, out_q} >= c_MOD;
    assign at_max    = (out_q == c_MAX);
    assign at_zero   = (out_q == '0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        out_d     = out_q;
        tick_d    = 1'b0;
        tc_d      = 1'b0;

        if (udc_clr) begin
            div_cnt_d = '0;
            out_d     = '0;
        end else if (udc_load) begin
            div_cnt_d = '0;
            out_d     = load_over ? c_MAX : udc_load_val;
        end else if (udc_en) begin
            div_cnt_d = step_evt ? 27'd0 : div_cnt_q + 27'd1;
            if (step_evt) begin
                tick_d = 1'b1;
                if (udc_dir) begin
                    // An out-of-range count cannot be reached. If it occurs,
                    // the next up-step returns the count to 0 and udc_tc stays low.
                    if (out_range) begin
                        out_d = '0;
                    end else if (at_max) begin
                        tc_d = 1'b1;
`ifdef UDC_SATURATE_EN
                        out_d = c_MAX;
`else
                        out_d = '0;
`endif
                    end else begin
                        out_d = out_q + WIDTH'(1);
                    end
                end else begin
                    if (out_range) begin
                        out_d = c_MAX;
                    end else if (at_zero) begin
                        tc_d = 1'b1;
`ifdef UDC_SATURATE_EN
                        out_d = '0;
`else
                        out_d = c_MAX;
`endif
                    end else begin
                        out_d = out_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge udc_clk or negedge udc_rst_n) begin
        if (!udc_rst_n) begin
            div_cnt_q <= '0;
            out_q     <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
        end
    end

    assign udc_out  = out_q;
    assign udc_tick = tick_q;
    assign udc_tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_udc_counter.sv
`default_nettype none
//============================================================================
// Module   : tb_udc_counter
// Purpose  : Self-checking bench for udc_counter (WIDTH=4, MODULUS=10,
//            CLK_DIVISION=10, 10 ns clock). A behavioural integer model
//            built from the counting rules predicts the outputs every cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_udc_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int DIV   = 10;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             en       = 1'b0;
    logic             clr      = 1'b0;
    logic             dir      = 1'b1;
    logic             load     = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             tc;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_out  = 0;
    int m_div  = 0;
    bit m_tick = 0;
    bit m_tc   = 0;

    udc_counter #(
        .WIDTH        (WIDTH),
        .MODULUS      (MOD),
        .CLK_DIVISION (27'd10)
    ) dut (
        .udc_clk      (clk),
        .udc_rst_n    (rst_n),
        .udc_en       (en),
        .udc_clr      (clr),
        .udc_dir      (dir),
        .udc_load     (load),
        .udc_load_val (load_val),
        .udc_out      (out),
        .udc_tick     (tick),
        .udc_tc       (tc)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, update the model with the inputs present at
    // that edge, then settle 1 ns so that the outputs can be sampled.
    task automatic model_edge();
        int lv;
        @(posedge clk);
        lv = int'(load_val);
        m_tick = 0;
        m_tc   = 0;
        if (!rst_n) begin
            m_out = 0;
            m_div = 0;
        end else if (clr) begin
            m_out = 0;
            m_div = 0;
        end else if (load) begin
            m_out = (lv >= MOD) ? MOD - 1 : lv;
            m_div = 0;
        end else if (en) begin
            if (m_div == DIV - 1) begin
                m_div  = 0;
                m_tick = 1;
                if (dir) begin
                    m_tc = (m_out == MOD - 1);
`ifdef UDC_SATURATE_EN
                    m_out = m_tc ? m_out : m_out + 1;
`else
                    m_out = (m_out + 1) % MOD;
`endif
                end else begin
                    m_tc = (m_out == 0);
`ifdef UDC_SATURATE_EN
                    m_out = m_tc ? m_out : m_out - 1;
`else
                    m_out = (m_out + MOD - 1) % MOD;
`endif
                end
            end else begin
                m_div = m_div + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || tick !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d tick=%b tc=%b required out=0 tick=0 tc=0", out, tick, tc);
        end
        #18;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            model_edge();
            checks++;
            if (out !== 4'd0 || tick !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: out=%0d tick=%b tc=%b required 0/0/0", i, out, tick, tc);
            end
        end
    endtask

    task automatic test_count_up();
        int n_tick = 0;
        int n_tc   = 0;
        @(negedge clk);
        en  = 1'b1;
        dir = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            model_edge();
            n_tick += int'(tick);
            n_tc   += int'(tc);
            checks++;
            if (int'(out) != m_out || tick !== m_tick || tc !== m_tc) begin
                errors++;
                $display("FAIL count_up cyc %0d: out=%0d tick=%b tc=%b required %0d/%b/%b",
                         i, out, tick, tc, m_out, m_tick, m_tc);
            end
            // Steps land on cycles 10, 20, ... and carry the value i/10 mod 10.
            if (i % 10 == 0) begin
                checks++;
                if (int'(out) != (i / 10) % 10 || tick !== 1'b1) begin
                    errors++;
                    $display("FAIL count_up_step %0d: out=%0d tick=%b required %0d/1", i, out, tick, (i / 10) % 10);
                end
            end
        end
        checks++;
        if (n_tick != 10 || n_tc != 1) begin
            errors++;
            $display("FAIL count_up_pulses: ticks=%0d tcs=%0d required 10/1", n_tick, n_tc);
        end
    endtask

    task automatic test_count_down();
        @(negedge clk);
        dir = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            model_edge();
            checks++;
            if (int'(out) != m_out || tick !== m_tick || tc !== m_tc) begin
                errors++;
                $display("FAIL count_down cyc %0d: out=%0d tick=%b tc=%b required %0d/%b/%b",
                         i, out, tick, tc, m_out, m_tick, m_tc);
            end
            if (i == 10) begin
                checks++;
                if (out !== 4'd9 || tc !== 1'b1) begin
                    errors++;
                    $display("FAIL down_wrap: out=%0d tc=%b required 9/1", out, tc);
                end
            end
        end
        checks++;
        if (out !== 4'd7) begin
            errors++;
            $display("FAIL down_end: out=%0d required 7", out);
        end
    endtask

    task automatic test_load_clr();
        logic [WIDTH-1:0] vals [3];
        logic [WIDTH-1:0] expv [3];
        logic             clrs [3];
        vals = '{4'd7, 4'd12, 4'd5};
        expv = '{4'd7, 4'd9, 4'd0};
        clrs = '{1'b0, 1'b0, 1'b1};
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load     = 1'b1;
            clr      = clrs[i];
            load_val = vals[i];
            model_edge();
            checks++;
            if (out !== expv[i] || int'(out) != m_out || tick !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL load_clr %0d: out=%0d tick=%b tc=%b required %0d/0/0", i, out, tick, tc, expv[i]);
            end
        end
        @(negedge clk);
        load = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        load     = 1'b1;
        load_val = 4'd5;
        model_edge();
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        dir  = 1'b1;
        for (int i = 0; i < 4; i++) model_edge();
        checks++;
        if (out !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset: out=%0d required 5", out);
        end
        #2 rst_n = 1'b0;
        m_out = 0; m_div = 0; m_tick = 0; m_tc = 0;
        #1;
        checks++;
        if (out !== 4'd0 || tick !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out=%0d tick=%b tc=%b required 0/0/0", out, tick, tc);
        end
        model_edge();
        checks++;
        if (out !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: out=%0d required 0", out);
        end
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            model_edge();
            checks++;
            if (int'(out) != m_out || tick !== m_tick || tc !== m_tc ||
                tick !== (i == 10) || int'(out) != ((i == 10) ? 1 : 0)) begin
                errors++;
                $display("FAIL post_reset cyc %0d: out=%0d tick=%b tc=%b required %0d/%b/%b",
                         i, out, tick, tc, m_out, m_tick, m_tc);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 9) != 0);
            dir      = ($urandom_range(0, 15) != 0) ? dir : ~dir;
            load     = ($urandom_range(0, 79) == 0);
            clr      = ($urandom_range(0, 119) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            model_edge();
            checks++;
            if (int'(out) != m_out || tick !== m_tick || tc !== m_tc) begin
                errors++;
                $display("FAIL random cyc %0d: out=%0d tick=%b tc=%b required %0d/%b/%b",
                         i, out, tick, tc, m_out, m_tick, m_tc);
            end
        end
        @(negedge clk);
        load = 1'b0;
        clr  = 1'b0;
    endtask

`ifdef UDC_SATURATE_EN
    task automatic test_saturate();
        logic [WIDTH-1:0] starts [2];
        logic             dirs   [2];
        int               n_tc;
        starts = '{4'd9, 4'd0};
        dirs   = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            load     = 1'b1;
            load_val = starts[k];
            model_edge();
            @(negedge clk);
            load = 1'b0;
            en   = 1'b1;
            dir  = dirs[k];
            n_tc = 0;
            for (int i = 0; i < 30; i++) begin
                model_edge();
                n_tc += int'(tc);
                checks++;
                if (out !== starts[k] || int'(out) != m_out || tc !== m_tc) begin
                    errors++;
                    $display("FAIL saturate %0d cyc %0d: out=%0d tc=%b required %0d/%b", k, i, out, tc, starts[k], m_tc);
                end
            end
            checks++;
            if (n_tc != 3) begin
                errors++;
                $display("FAIL saturate_tc %0d: tcs=%0d required 3", k, n_tc);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clr();
        test_async_reset();
`ifdef UDC_SATURATE_EN
        test_saturate();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
